// File: rtl/mem_block_mover_if.sv
// Word-memory bus between the block mover (master) and a single-port memory (slave).
// Reads are combinational; a write happens on the rising clock edge while mem_write is high.
interface mem_block_mover_if #(
    parameter int word_size = 8
);
    logic [word_size-1:0] mem_address;
    logic                 mem_write;
    logic [word_size-1:0] mem_wdata;
    logic [word_size-1:0] mem_rdata;

    modport master (
        output mem_address,
        output mem_write,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_address,
        input  mem_write,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / pattern fill engine driving a single-port word memory directly.
//
// state | meaning
// IDLE  | waiting for start; memory outputs parked at zero
// READ  | source word presented on the address lines, captured into hold
// WRITE | hold written to the destination, pointers advance
// FILL  | pattern written to the destination, pointer advances
// DONE  | one-cycle completion pulse, then back to IDLE
module mem_block_mover #(
    parameter int word_size   = 8,
    parameter int memory_size = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [word_size-1:0] src_addr,
    input  logic [word_size-1:0] dst_addr,
    input  logic [word_size-1:0] length,
    input  logic [word_size-1:0] pattern,
    mem_block_mover_if.master    mem,
    output logic                 busy,
    output logic                 done
);
    // Pointers are sized from the memory depth so increments wrap at the top of memory.
    localparam int addr_width = $clog2(memory_size);

    typedef logic [addr_width-1:0] addr_t;
    typedef logic [word_size-1:0]  word_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        FILL,
        DONE
    } state_t;

    state_t state;
    addr_t  src_ptr;
    addr_t  dst_ptr;
    word_t  remaining;
    word_t  pat;
    word_t  hold;
    addr_t  address_q;
    logic   write_q;
    logic   busy_q;
    logic   done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            pat       <= '0;
            hold      <= '0;
            address_q <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        pat       <= pattern;
                        if (length == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else if (!mode) begin
                            state     <= READ;
                            busy_q    <= 1'b1;
                            address_q <= src_addr;
                        end else begin
                            state     <= FILL;
                            busy_q    <= 1'b1;
                            address_q <= dst_addr;
                            hold      <= pattern;
                            write_q   <= 1'b1;
                        end
                    end
                end

                READ: begin
                    // hold doubles as the write-data register, so it is valid in WRITE.
                    hold      <= mem.mem_rdata;
                    state     <= WRITE;
                    address_q <= dst_ptr;
                    write_q   <= 1'b1;
                end

                WRITE: begin
                    src_ptr   <= src_ptr + 1'b1;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == word_t'(1)) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        write_q   <= 1'b0;
                        address_q <= '0;
                        hold      <= '0;
                    end else begin
                        state     <= READ;
                        address_q <= src_ptr + 1'b1;
                        write_q   <= 1'b0;
                        hold      <= '0;
                    end
                end

                FILL: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == word_t'(1)) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        write_q   <= 1'b0;
                        address_q <= '0;
                        hold      <= '0;
                    end else begin
                        address_q <= dst_ptr + 1'b1;
                        hold      <= pat;
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    write_q   <= 1'b0;
                    address_q <= '0;
                    hold      <= '0;
                end
            endcase
        end
    end

    // Gating by rst keeps the memory untouched on the edge that aborts a transfer.
    assign mem.mem_write   = write_q & ~rst;
    assign mem.mem_address = address_q;
    assign mem.mem_wdata   = hold;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover: expected writes and done cycles are queued at issue time
// and a forked monitor checks every write strobe and done pulse the engine produces.
module tb_mem_block_mover;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] length;
    logic [7:0] pattern;
    logic       busy;
    logic       done;

    logic       poke_en;
    logic [7:0] poke_addr;
    logic [7:0] poke_data;
    logic [7:0] mem_arr [256];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    wr_t exp_wr[$];
    int  exp_done[$];

    mem_block_mover_if #(.word_size(8)) bus ();

    mem_block_mover #(.word_size(8), .memory_size(256)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .pattern  (pattern),
        .mem      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_write) mem_arr[bus.mem_address] <= bus.mem_wdata;
        if (poke_en) mem_arr[poke_addr] <= poke_data;
    end

    assign bus.mem_rdata = mem_arr[bus.mem_address];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    // Drives a start pulse; done_at > 0 queues the expected done cycle relative to the start edge.
    task automatic issue(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] p, input int done_at,
                         output int c0);
        @(negedge clk);
        mode     = m;
        src_addr = s;
        dst_addr = d;
        length   = l;
        pattern  = p;
        start    = 1'b1;
        c0       = cyc;
        if (done_at > 0) exp_done.push_back(c0 + done_at);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            #2;
            if (bus.mem_write) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL write_unexpected: got addr %0h data %0h, required no write (cycle %0d)",
                             bus.mem_address, bus.mem_wdata, cyc);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr", int'(bus.mem_address), int'(e.addr));
                    check("write_data", int'(bus.mem_wdata), int'(e.data));
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_done.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL done_unexpected: got done=1, required 0 (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                end
                check("busy_with_done", int'(busy), 0);
            end
        end
    endtask

    task automatic check_queues(input string tag);
        check({tag, "_writes_pending"}, exp_wr.size(), 0);
        check({tag, "_done_pending"}, exp_done.size(), 0);
    endtask

    initial begin
        int c0;
        int b0;
        int w0;
        rst      = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        pattern  = '0;
        poke_en  = 1'b0;
        poke_addr = '0;
        poke_data = '0;
        fork
            monitor();
        join_none

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);

        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_write", int'(bus.mem_write), 0);
        check("rst_address", int'(bus.mem_address), 0);
        check("rst_wdata", int'(bus.mem_wdata), 0);
        rst = 1'b0;

        // Plain copy
        poke(8'd10, 8'hA1);
        poke(8'd11, 8'hB2);
        poke(8'd12, 8'hC3);
        push_wr(8'd40, 8'hA1);
        push_wr(8'd41, 8'hB2);
        push_wr(8'd42, 8'hC3);
        b0 = busy_cnt;
        w0 = wr_cnt;
        issue(1'b0, 8'd10, 8'd40, 8'd3, 8'h00, 7, c0);
        repeat (9) @(negedge clk);
        check("copy_busy_cycles", busy_cnt - b0, 6);
        check("copy_write_strobes", wr_cnt - w0, 3);
        check("copy_dst40", int'(mem_arr[40]), 'hA1);
        check("copy_dst41", int'(mem_arr[41]), 'hB2);
        check("copy_dst42", int'(mem_arr[42]), 'hC3);
        check("copy_src10", int'(mem_arr[10]), 'hA1);
        check("copy_src12", int'(mem_arr[12]), 'hC3);
        check_queues("copy");

        // Fill across the top of memory
        poke(8'd2, 8'h77);
        push_wr(8'd254, 8'h5A);
        push_wr(8'd255, 8'h5A);
        push_wr(8'd0, 8'h5A);
        push_wr(8'd1, 8'h5A);
        b0 = busy_cnt;
        issue(1'b1, 8'h00, 8'd254, 8'd4, 8'h5A, 5, c0);
        repeat (6) @(negedge clk);
        check("fill_busy_cycles", busy_cnt - b0, 4);
        check("fill_mem254", int'(mem_arr[254]), 'h5A);
        check("fill_mem255", int'(mem_arr[255]), 'h5A);
        check("fill_mem0", int'(mem_arr[0]), 'h5A);
        check("fill_mem1", int'(mem_arr[1]), 'h5A);
        check("fill_mem2_untouched", int'(mem_arr[2]), 'h77);
        check_queues("fill");

        // Zero length
        b0 = busy_cnt;
        w0 = wr_cnt;
        issue(1'b0, 8'd10, 8'd40, 8'd0, 8'h00, 1, c0);
        repeat (3) @(negedge clk);
        check("zero_busy_cycles", busy_cnt - b0, 0);
        check("zero_write_strobes", wr_cnt - w0, 0);
        check_queues("zero");

        // Starts during a copy and during DONE are ignored
        poke(8'd100, 8'h44);
        poke(8'd120, 8'h33);
        poke(8'd130, 8'h11);
        push_wr(8'd60, 8'hA1);
        push_wr(8'd61, 8'hB2);
        push_wr(8'd62, 8'hC3);
        w0 = wr_cnt;
        issue(1'b0, 8'd10, 8'd60, 8'd3, 8'h00, 7, c0);
        mode     = 1'b0;
        src_addr = 8'd100;
        dst_addr = 8'd120;
        length   = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 7) @(negedge clk);
        mode     = 1'b1;
        dst_addr = 8'd130;
        length   = 8'd2;
        pattern  = 8'hEE;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_start_writes", wr_cnt - w0, 3);
        check("busy_start_mem62", int'(mem_arr[62]), 'hC3);
        check("busy_start_mem120", int'(mem_arr[120]), 'h33);
        check("busy_start_mem130", int'(mem_arr[130]), 'h11);
        check_queues("busy_start");

        // Reset in the second WRITE of a four-word copy
        poke(8'd13, 8'hD4);
        poke(8'd81, 8'h99);
        push_wr(8'd80, 8'hA1);
        issue(1'b0, 8'd10, 8'd80, 8'd4, 8'h00, 0, c0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_address", int'(bus.mem_address), 0);
        check("abort_wdata", int'(bus.mem_wdata), 0);
        rst = 1'b0;
        #1;
        check("abort_write", int'(bus.mem_write), 0);
        check("abort_mem80", int'(mem_arr[80]), 'hA1);
        check("abort_mem81", int'(mem_arr[81]), 'h99);
        push_wr(8'd90, 8'h3C);
        issue(1'b1, 8'h00, 8'd90, 8'd1, 8'h3C, 2, c0);
        repeat (4) @(negedge clk);
        check("restart_mem90", int'(mem_arr[90]), 'h3C);
        check_queues("restart");

        // Forward overlapping copy replicates the first word
        poke(8'd20, 8'h01);
        poke(8'd21, 8'h02);
        poke(8'd22, 8'h03);
        push_wr(8'd21, 8'h01);
        push_wr(8'd22, 8'h01);
        issue(1'b0, 8'd20, 8'd21, 8'd2, 8'h00, 5, c0);
        repeat (7) @(negedge clk);
        check("overlap_mem21", int'(mem_arr[21]), 'h01);
        check("overlap_mem22", int'(mem_arr[22]), 'h01);
        check_queues("overlap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
